// File: rtl/mc_chroma_ip_np_pkg.sv
// Shared definitions for the chroma interpolator: FSM encoding, shift constants
// and the HEVC 4-tap chroma coefficient table.
package mc_chroma_ip_np_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam int V_SHIFT = 6;

  function automatic int h_shift(input int pw);
    return pw - 8;
  endfunction

  function automatic int out_shift(input int pw);
    return 14 - pw;
  endfunction

  // Row packed with tap 0 in the most significant byte.
  function automatic logic signed [7:0] chroma_coef(input logic [2:0] frac, input logic [1:0] tap);
    logic [31:0] row;
    case (frac)
      3'd1:    row = {-8'sd2, 8'sd58, 8'sd10, -8'sd2};
      3'd2:    row = {-8'sd4, 8'sd54, 8'sd16, -8'sd2};
      3'd3:    row = {-8'sd6, 8'sd46, 8'sd28, -8'sd4};
      3'd4:    row = {-8'sd4, 8'sd36, 8'sd36, -8'sd4};
      3'd5:    row = {-8'sd4, 8'sd28, 8'sd46, -8'sd6};
      3'd6:    row = {-8'sd2, 8'sd16, 8'sd54, -8'sd4};
      3'd7:    row = {-8'sd2, 8'sd10, 8'sd58, -8'sd2};
      default: row = {8'sd0, 8'sd64, 8'sd0, 8'sd0};
    endcase
    return row[8 * (3 - int'(tap)) +: 8];
  endfunction

endpackage

// File: rtl/mc_chroma_tap4.sv
// Four-tap chroma filter: signed 16-bit samples (tap t at bits [t*16 +: 16]),
// phase-selected coefficients, arithmetic right shift by SHIFT.
module mc_chroma_tap4
  import mc_chroma_ip_np_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic [2:0]  i_frac,
  input  logic [63:0] i_s,
  output logic [15:0] o_y
);

  logic signed [25:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int t = 0; t < 4; t++) begin
      w_acc = w_acc + 26'(chroma_coef(i_frac, 2'(t))) * 26'($signed(i_s[t*16 +: 16]));
    end
  end

  assign o_y = 16'(w_acc >>> SHIFT);

endmodule

// File: rtl/mc_chroma_ip_np.sv
// Separable HEVC chroma interpolator: per-lane horizontal filter on each input
// row, vertical filter over the row history, then bipred or clipped pixel output.
module mc_chroma_ip_np
  import mc_chroma_ip_np_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int LANES       = 4,
  parameter int H_W         = 6
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             blk_start_i,
  input  logic [2:0]                       fracx_i,
  input  logic [2:0]                       fracy_i,
  input  logic [H_W-1:0]                   blk_h_i,
  input  logic                             bipred_i,
  input  logic                             ref_valid_i,
  output logic                             ref_ready_o,
  input  logic [(LANES+3)*PIXEL_WIDTH-1:0] ref_p_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [LANES*16-1:0]              out_p_o,
  output logic                             blk_done_o,
  output logic [1:0]                       dbg_state_o
);

  localparam int PW = PIXEL_WIDTH;
  localparam logic signed [16:0] MAXV = 17'((1 << PW) - 1);
  localparam logic signed [16:0] RND  = 17'(1 << (13 - PW));

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_fracx, r_fracy;
  logic [H_W-1:0]      r_blk_h, r_row_cnt, r_out_cnt;
  logic                r_bipred, r_out_valid;
  logic [LANES*16-1:0] r_out_p;
  logic [LANES*16-1:0] r_hist [3];
  logic [LANES*16-1:0] w_h, w_v, w_fmt;
  logic                w_acc_row, w_out_hs, w_last_hs, w_room;

  // Handshakes: a transfer happens in a cycle where valid and ready are both high;
  // valid never depends on ready, and out_p_o holds while out_valid_o waits.
  assign w_acc_row   = ref_valid_i && ref_ready_o;
  assign w_out_hs    = r_out_valid && out_ready_i;
  assign w_last_hs   = w_out_hs && (({1'b0, r_out_cnt} + 1'b1) == {1'b0, r_blk_h});
  assign w_room      = r_row_cnt < r_blk_h;
  assign out_valid_o = r_out_valid;
  assign out_p_o     = r_out_p;
  assign dbg_state_o = r_state;
  assign blk_done_o  = (r_state == ST_RUN) && ((r_blk_h == '0) || w_last_hs);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [63:0]        w_hin, w_vin;
    logic signed [16:0] w_rnd, w_sc;
    logic [15:0]        w_clip;

    assign w_hin = {16'(ref_p_i[(j+3)*PW +: PW]), 16'(ref_p_i[(j+2)*PW +: PW]),
                    16'(ref_p_i[(j+1)*PW +: PW]), 16'(ref_p_i[j*PW +: PW])};

    // With fracy 0 the centre tap must land on the incoming row so output is not delayed.
    assign w_vin = (r_fracy == 3'd0) ?
                   {32'd0, w_h[j*16 +: 16], r_hist[2][j*16 +: 16]} :
                   {w_h[j*16 +: 16], r_hist[2][j*16 +: 16], r_hist[1][j*16 +: 16], r_hist[0][j*16 +: 16]};

    mc_chroma_tap4 #(.SHIFT(h_shift(PW))) u_h (
      .i_frac (r_fracx),
      .i_s    (w_hin),
      .o_y    (w_h[j*16 +: 16])
    );

    mc_chroma_tap4 #(.SHIFT(V_SHIFT)) u_v (
      .i_frac (r_fracy),
      .i_s    (w_vin),
      .o_y    (w_v[j*16 +: 16])
    );

    always_comb begin
      w_rnd = 17'($signed(w_v[j*16 +: 16])) + RND;
      w_sc  = w_rnd >>> out_shift(PW);
      if (w_sc < 17'sd0)     w_clip = '0;
      else if (w_sc > MAXV)  w_clip = 16'(MAXV);
      else                   w_clip = 16'(w_sc);
    end

    assign w_fmt[j*16 +: 16] = r_bipred ? w_v[j*16 +: 16] : w_clip;
  end

  always_comb begin
    ref_ready_o = 1'b0;
    case (r_state)
      ST_PRIME: ref_ready_o = 1'b1;
      ST_RUN:   ref_ready_o = (!r_out_valid || out_ready_i) && w_room;
      default:  ref_ready_o = 1'b0;
    endcase
    if (blk_start_i) ref_ready_o = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (blk_start_i) begin
      w_state_nxt = (fracy_i != 3'd0 && blk_h_i != '0) ? ST_PRIME : ST_RUN;
    end else begin
      case (r_state)
        ST_PRIME: if (w_acc_row && r_row_cnt == H_W'(2)) w_state_nxt = ST_RUN;
        ST_RUN:   if (r_blk_h == '0 || w_last_hs) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fracx     <= '0;
      r_fracy     <= '0;
      r_blk_h     <= '0;
      r_bipred    <= 1'b0;
      r_row_cnt   <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_p     <= '0;
      for (int i = 0; i < 3; i++) r_hist[i] <= '0;
    end else if (blk_start_i) begin
      r_fracx     <= fracx_i;
      r_fracy     <= fracy_i;
      r_blk_h     <= blk_h_i;
      r_bipred    <= bipred_i;
      r_row_cnt   <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < 3; i++) r_hist[i] <= '0;
    end else begin
      if (w_acc_row) begin
        r_hist[0] <= r_hist[1];
        r_hist[1] <= r_hist[2];
        r_hist[2] <= w_h;
        if (r_state == ST_PRIME && r_row_cnt == H_W'(2)) r_row_cnt <= '0;
        else                                             r_row_cnt <= r_row_cnt + 1'b1;
      end
      if (r_state == ST_RUN && w_acc_row) begin
        r_out_valid <= 1'b1;
        r_out_p     <= w_fmt;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
      if (w_out_hs) r_out_cnt <= w_last_hs ? '0 : r_out_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_chroma_ip_np.sv
// Directed bench for mc_chroma_ip_np: an 8-bit instance for the main flows and a
// 10-bit instance for the reset/full-range case.
module tb_mc_chroma_ip_np;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, blk_start, bipred, ref_valid, ref_ready, out_valid, out_ready, blk_done;
  logic [2:0]  fracx, fracy;
  logic [5:0]  blk_h;
  logic [55:0] ref_p;
  logic [63:0] out_p;
  logic [1:0]  dbg_state;

  logic        rstn_10, blk_start_10, bipred_10, ref_valid_10, ref_ready_10, out_valid_10, out_ready_10, blk_done_10;
  logic [2:0]  fracx_10, fracy_10;
  logic [5:0]  blk_h_10;
  logic [69:0] ref_p_10;
  logic [63:0] out_p_10;
  logic [1:0]  dbg_state_10;

  mc_chroma_ip_np #(.PIXEL_WIDTH(8), .LANES(4), .H_W(6)) dut (
    .clk(clk), .rstn(rstn), .blk_start_i(blk_start), .fracx_i(fracx), .fracy_i(fracy),
    .blk_h_i(blk_h), .bipred_i(bipred), .ref_valid_i(ref_valid), .ref_ready_o(ref_ready),
    .ref_p_i(ref_p), .out_valid_o(out_valid), .out_ready_i(out_ready), .out_p_o(out_p),
    .blk_done_o(blk_done), .dbg_state_o(dbg_state)
  );

  mc_chroma_ip_np #(.PIXEL_WIDTH(10), .LANES(4), .H_W(6)) dut10 (
    .clk(clk), .rstn(rstn_10), .blk_start_i(blk_start_10), .fracx_i(fracx_10), .fracy_i(fracy_10),
    .blk_h_i(blk_h_10), .bipred_i(bipred_10), .ref_valid_i(ref_valid_10), .ref_ready_o(ref_ready_10),
    .ref_p_i(ref_p_10), .out_valid_o(out_valid_10), .out_ready_i(out_ready_10), .out_p_o(out_p_10),
    .blk_done_o(blk_done_10), .dbg_state_o(dbg_state_10)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  int          acc_cnt, hs_cnt, done_cnt, done_at, row_val, row_inc, prime_left;
  bit          use_fixed, sb_push;
  logic [63:0] fixed_exp;

  function automatic logic [55:0] fill8(input int v);
    logic [55:0] r;
    for (int k = 0; k < 7; k++) r[k*8 +: 8] = 8'(v);
    return r;
  endfunction

  function automatic logic [69:0] fill10(input int v);
    logic [69:0] r;
    for (int k = 0; k < 7; k++) r[k*10 +: 10] = 10'(v);
    return r;
  endfunction

  function automatic logic [55:0] alt_row();
    logic [55:0] r;
    for (int k = 0; k < 7; k++) r[k*8 +: 8] = (k % 2 == 1) ? 8'd255 : 8'd0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (8-bit instance) ----------------
  task automatic reset_counts();
    acc_cnt = 0; hs_cnt = 0; done_cnt = 0; done_at = -1;
    exp_q.delete();
    sb_push = 1'b1; use_fixed = 1'b0; prime_left = 0;
  endtask

  task automatic step(input string tag);
    bit acc;
    #1;
    acc = ref_valid && ref_ready;
    if (blk_start) check({tag, "_start_ready"}, 64'(ref_ready), 64'd0);
    if (acc) begin
      acc_cnt++;
      if (prime_left > 0) prime_left--;
      else if (sb_push) exp_q.push_back(use_fixed ? fixed_exp : {4{16'(row_val)}});
    end
    if (out_valid && out_ready) begin
      hs_cnt++;
      check({tag, "_out_expected"}, 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check({tag, "_out_p"}, out_p, exp_q.pop_front());
    end
    if (blk_done) begin
      done_cnt++;
      done_at = hs_cnt;
    end
    @(negedge clk);
    if (acc && !use_fixed) begin
      row_val = row_val + row_inc;
      ref_p   = fill8(row_val);
    end
  endtask

  task automatic start_blk(input int fx, input int fy, input int h, input bit bp, input string tag);
    blk_start = 1'b1; fracx = 3'(fx); fracy = 3'(fy); blk_h = 6'(h); bipred = bp;
    step(tag);
    blk_start = 1'b0;
  endtask

  task automatic run_fixed(input int fx, input int fy, input int h, input bit bp,
                           input logic [55:0] row, input logic [63:0] expw, input int rows_exp, input string tag);
    reset_counts();
    use_fixed  = 1'b1;
    fixed_exp  = expw;
    prime_left = (fy != 0 && h != 0) ? 3 : 0;
    ref_p = row; ref_valid = 1'b1; out_ready = 1'b1;
    start_blk(fx, fy, h, bp, tag);
    for (int c = 0; c < 30; c++) step(tag);
    ref_valid = 1'b0;
    check({tag, "_rows"},     64'(acc_cnt), 64'(rows_exp));
    check({tag, "_outs"},     64'(hs_cnt), 64'(h));
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_at"},  64'(done_at), 64'(h));
    check({tag, "_q_empty"},  64'(exp_q.size()), 64'd0);
    check({tag, "_idle"},     64'(dbg_state), 64'd0);
  endtask

  // ---------------- driver task (10-bit instance) ----------------
  task automatic run10(input int fx, input int fy, input int h, input bit bp,
                       input int pix, input logic [63:0] expw, input int rows_exp, input string tag);
    int a, hc, d;
    a = 0; hc = 0; d = 0;
    blk_start_10 = 1'b1; fracx_10 = 3'(fx); fracy_10 = 3'(fy); blk_h_10 = 6'(h); bipred_10 = bp;
    ref_valid_10 = 1'b1; ref_p_10 = fill10(pix); out_ready_10 = 1'b1;
    #1 check({tag, "_start_ready"}, 64'(ref_ready_10), 64'd0);
    @(negedge clk);
    blk_start_10 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (ref_valid_10 && ref_ready_10) a++;
      if (out_valid_10 && out_ready_10) begin
        hc++;
        check({tag, "_out_p"}, out_p_10, expw);
      end
      if (blk_done_10) d++;
      @(negedge clk);
    end
    ref_valid_10 = 1'b0;
    check({tag, "_rows"},     64'(a), 64'(rows_exp));
    check({tag, "_outs"},     64'(hc), 64'(h));
    check({tag, "_done_cnt"}, 64'(d), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rstn = 1'b0; blk_start = 1'b0; fracx = '0; fracy = '0; blk_h = '0; bipred = 1'b0;
    ref_valid = 1'b0; ref_p = '0; out_ready = 1'b0;
    rstn_10 = 1'b0; blk_start_10 = 1'b0; fracx_10 = '0; fracy_10 = '0; blk_h_10 = '0; bipred_10 = 1'b0;
    ref_valid_10 = 1'b0; ref_p_10 = '0; out_ready_10 = 1'b0;
    reset_counts();
    row_val = 0; row_inc = 0; fixed_exp = '0;

    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ref_ready", 64'(ref_ready), 64'd0);
    check("rst_blk_done",  64'(blk_done), 64'd0);
    check("rst_out_p",     out_p, 64'd0);
    check("rst_state",     64'(dbg_state), 64'd0);
    @(negedge clk);
    rstn = 1'b1; rstn_10 = 1'b1;
    @(negedge clk);

    // Full-pel: 100 passes straight through.
    run_fixed(0, 0, 4, 1'b0, fill8(100), {4{16'd100}}, 4, "fullpel");
    // Half-pel both directions on flat 200: 3 priming rows plus 2.
    run_fixed(4, 4, 2, 1'b0, fill8(200), {4{16'd200}}, 5, "halfpel");
    run_fixed(4, 4, 2, 1'b1, fill8(200), {4{16'd12800}}, 5, "halfpel_bi");
    // Alternating 0/255 columns with fracx=1: even lanes 223, odd lanes 32.
    run_fixed(1, 0, 2, 1'b0, alt_row(), {16'd32, 16'd223, 16'd32, 16'd223}, 2, "clip");
    // Empty block: no rows, done pulse only.
    run_fixed(0, 0, 0, 1'b0, fill8(5), 64'd0, 0, "h0");

    // Vertical half-pel over rows 10,20,...: outputs 25 then 35.
    reset_counts();
    sb_push = 1'b0;
    exp_q.push_back({4{16'd25}});
    exp_q.push_back({4{16'd35}});
    row_val = 10; row_inc = 10; ref_p = fill8(10); ref_valid = 1'b1; out_ready = 1'b1;
    start_blk(0, 4, 2, 1'b0, "vert");
    for (int c = 0; c < 30; c++) step("vert");
    ref_valid = 1'b0;
    check("vert_rows",    64'(acc_cnt), 64'd5);
    check("vert_outs",    64'(hs_cnt), 64'd2);
    check("vert_q_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: stall 5 cycles after the first output.
    reset_counts();
    row_val = 10; row_inc = 10; ref_p = fill8(10); ref_valid = 1'b1; out_ready = 1'b1;
    start_blk(0, 0, 4, 1'b0, "bp");
    for (int c = 0; c < 20 && hs_cnt < 1; c++) step("bp");
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step("bp");
      check("bp_stall_ready", 64'(ref_ready), 64'd0);
      check("bp_stall_valid", 64'(out_valid), 64'd1);
      check("bp_stall_hold",  out_p, {4{16'd20}});
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && hs_cnt < 4; c++) step("bp");
    for (int c = 0; c < 3; c++) step("bp");
    ref_valid = 1'b0;
    check("bp_rows",     64'(acc_cnt), 64'd4);
    check("bp_outs",     64'(hs_cnt), 64'd4);
    check("bp_done_cnt", 64'(done_cnt), 64'd1);
    check("bp_done_at",  64'(done_at), 64'd4);
    check("bp_q_empty",  64'(exp_q.size()), 64'd0);

    // Abort an 8-row block on its second output; new 3-row block follows.
    reset_counts();
    row_val = 10; row_inc = 10; ref_p = fill8(10); ref_valid = 1'b1; out_ready = 1'b1;
    start_blk(0, 0, 8, 1'b0, "abort");
    for (int c = 0; c < 20 && hs_cnt < 1; c++) step("abort");
    start_blk(0, 0, 3, 1'b0, "abort");
    check("abort_hs_at_start", 64'(hs_cnt), 64'd2);
    check("abort_no_done",     64'(done_cnt), 64'd0);
    #1 check("abort_valid_drop", 64'(out_valid), 64'd0);
    check("abort_q_empty", 64'(exp_q.size()), 64'd0);
    acc_cnt = 0; hs_cnt = 0; done_cnt = 0; done_at = -1;
    for (int c = 0; c < 20 && hs_cnt < 3; c++) step("abort_new");
    for (int c = 0; c < 3; c++) step("abort_new");
    ref_valid = 1'b0;
    check("abort_new_rows",     64'(acc_cnt), 64'd3);
    check("abort_new_outs",     64'(hs_cnt), 64'd3);
    check("abort_new_done_cnt", 64'(done_cnt), 64'd1);
    check("abort_new_done_at",  64'(done_at), 64'd3);

    // 10-bit instance: bipred full range, then reset during PRIME, then pixel output.
    run10(0, 0, 2, 1'b1, 1023, {4{16'd16368}}, 2, "pw10_bi");
    blk_start_10 = 1'b1; fracx_10 = 3'd0; fracy_10 = 3'd4; blk_h_10 = 6'd2; bipred_10 = 1'b0;
    @(negedge clk);
    blk_start_10 = 1'b0; ref_valid_10 = 1'b1; ref_p_10 = fill10(500);
    #1 check("pw10_prime_ready", 64'(ref_ready_10), 64'd1);
    @(negedge clk);
    rstn_10 = 1'b0;
    #1;
    check("pw10_rst_valid", 64'(out_valid_10), 64'd0);
    check("pw10_rst_ready", 64'(ref_ready_10), 64'd0);
    check("pw10_rst_done",  64'(blk_done_10), 64'd0);
    check("pw10_rst_out_p", out_p_10, 64'd0);
    check("pw10_rst_state", 64'(dbg_state_10), 64'd0);
    @(negedge clk);
    rstn_10 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 check("pw10_post_rst_ready", 64'(ref_ready_10), 64'd0);
      check("pw10_post_rst_valid", 64'(out_valid_10), 64'd0);
      @(negedge clk);
    end
    ref_valid_10 = 1'b0;
    run10(0, 0, 2, 1'b0, 1023, {4{16'd1023}}, 2, "pw10_pix");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
